// File: rtl/uart_tx_framer.sv
// ============================================================================
// uart_tx_framer : UART transmit framer (serializer, parity, frame FSM, line)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TICK = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_PARITY    = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;

  localparam logic [CW-1:0] c_LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] c_LAST_STOP = CW'(STOP_BITS - 1);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx_framer: DATA_WIDTH must be 5..9 and STOP_BITS 1 or 2");
    end
  endgenerate

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (DATA_VALID) state_d = S_WAIT_TICK;
      S_WAIT_TICK: if (TICK) state_d = S_START;
      S_START:     if (TICK) state_d = S_DATA;
      S_DATA:      if (TICK && cnt_q == c_LAST_DATA) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY:    if (TICK) state_d = S_STOP;
      S_STOP:      if (TICK && cnt_q == c_LAST_STOP) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: the state being entered names the bit now driven
  always_comb begin
    tx_d      = tx_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    cnt_d     = cnt_q;
    BUSY      = (state_q != S_IDLE);

    if (state_q == S_IDLE && DATA_VALID) begin
      shift_d   = P_DATA;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
      par_en_d  = PAR_EN;
    end

    if (TICK && state_q != S_IDLE) begin
      case (state_d)
        S_START:  tx_d = 1'b0;
        S_DATA: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
        S_PARITY: tx_d = par_bit_q;
        S_STOP:   tx_d = 1'b1;
        S_IDLE: begin
          tx_d   = 1'b1;
          done_d = 1'b1;
        end
        default:  tx_d = 1'b1;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (TICK && (state_q == S_DATA || state_q == S_STOP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign TX_OUT = tx_q;
  assign DONE   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// ============================================================================
// tb_uart_tx_framer : frame-level reference model bench for uart_tx_framer
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_framer;

  logic       CLK;
  logic       RST;
  logic       TICK;
  logic [7:0] P_DATA_A;
  logic       DATA_VALID_A, PAR_EN_A, PAR_TYP_A;
  logic       TX_OUT_A, BUSY_A, DONE_A;
  logic [6:0] P_DATA_B;
  logic       DATA_VALID_B, PAR_EN_B, PAR_TYP_B;
  logic       TX_OUT_B, BUSY_B, DONE_B;

  uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut_a (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA_A), .DATA_VALID(DATA_VALID_A),
    .PAR_EN(PAR_EN_A), .PAR_TYP(PAR_TYP_A), .TX_OUT(TX_OUT_A), .BUSY(BUSY_A), .DONE(DONE_A)
  );

  uart_tx_framer #(.DATA_WIDTH(7), .STOP_BITS(2)) u_dut_b (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(P_DATA_B), .DATA_VALID(DATA_VALID_B),
    .PAR_EN(PAR_EN_B), .PAR_TYP(PAR_TYP_B), .TX_OUT(TX_OUT_B), .BUSY(BUSY_B), .DONE(DONE_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tick_per;
  initial begin
    int tcnt;
    tcnt = 0;
    TICK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      tcnt = tcnt + 1;
      if (tcnt >= tick_per) tcnt = 0;
      TICK = (tcnt == 0);
    end
  end

  // Frame as a bit list: start, data LSB first, optional parity, stop bits
  function automatic logic [15:0] build_frame(input int dw, input logic [8:0] d,
                                              input logic pen, input logic ptyp);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (pen) f[1+dw] = ((ones % 2) == 1) ^ ptyp;
    return f;
  endfunction

  logic [15:0] ma_frame, mb_frame;
  int          ma_len, mb_len, ma_idx, mb_idx;
  logic        ma_act, mb_act, ma_line, mb_line, ma_done, mb_done;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ma_act <= 1'b0; ma_line <= 1'b1; ma_done <= 1'b0; ma_idx <= 0;
      ma_len <= 0; ma_frame <= '1;
    end else begin
      ma_done <= 1'b0;
      if (ma_act) begin
        if (TICK) begin
          if (ma_idx < ma_len) begin
            ma_line <= ma_frame[ma_idx];
            ma_idx  <= ma_idx + 1;
          end else begin
            ma_act <= 1'b0; ma_done <= 1'b1; ma_line <= 1'b1;
          end
        end
      end else if (DATA_VALID_A) begin
        ma_act   <= 1'b1;
        ma_idx   <= 0;
        ma_frame <= build_frame(8, {1'b0, P_DATA_A}, PAR_EN_A, PAR_TYP_A);
        ma_len   <= 1 + 8 + int'(PAR_EN_A) + 1;
      end
    end
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mb_act <= 1'b0; mb_line <= 1'b1; mb_done <= 1'b0; mb_idx <= 0;
      mb_len <= 0; mb_frame <= '1;
    end else begin
      mb_done <= 1'b0;
      if (mb_act) begin
        if (TICK) begin
          if (mb_idx < mb_len) begin
            mb_line <= mb_frame[mb_idx];
            mb_idx  <= mb_idx + 1;
          end else begin
            mb_act <= 1'b0; mb_done <= 1'b1; mb_line <= 1'b1;
          end
        end
      end else if (DATA_VALID_B) begin
        mb_act   <= 1'b1;
        mb_idx   <= 0;
        mb_frame <= build_frame(7, {2'b00, P_DATA_B}, PAR_EN_B, PAR_TYP_B);
        mb_len   <= 1 + 7 + int'(PAR_EN_B) + 2;
      end
    end
  end

  int   n_tests, n_fail;
  logic hist_a [0:8191];
  logic hist_b [0:8191];
  int   cap_a, cap_b;
  logic pend_a, pend_b, dn_a, dn_b;

  task automatic chk(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Compare with the model and record each launched bit (TICK while busy, no DONE)
  task automatic check_all();
    chk("tx_a", TX_OUT_A, ma_line);
    chk("busy_a", BUSY_A, ma_act);
    chk("done_a", DONE_A, ma_done);
    chk("tx_b", TX_OUT_B, mb_line);
    chk("busy_b", BUSY_B, mb_act);
    chk("done_b", DONE_B, mb_done);
    if (pend_a && !DONE_A && cap_a < 8192) begin hist_a[cap_a] = TX_OUT_A; cap_a++; end
    if (pend_b && !DONE_B && cap_b < 8192) begin hist_b[cap_b] = TX_OUT_B; cap_b++; end
    pend_a = TICK && BUSY_A;
    pend_b = TICK && BUSY_B;
    dn_a = DONE_A;
    dn_b = DONE_B;
  endtask

  task automatic step();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bits(input string name, input bit inst, input int start,
                            input int n, input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    for (int i = 0; i < n; i++) got[i] = inst ? hist_b[start+i] : hist_a[start+i];
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic wait_done(input string name, input bit inst);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      step();
      n++;
      seen = inst ? dn_b : dn_a;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic pen, input logic ptyp);
    DATA_VALID_A = 1'b1; P_DATA_A = d; PAR_EN_A = pen; PAR_TYP_A = ptyp;
    step();
    DATA_VALID_A = 1'b0;
  endtask

  initial begin
    int start, n;
    n_tests = 0; n_fail = 0; cap_a = 0; cap_b = 0;
    pend_a = 0; pend_b = 0; dn_a = 0; dn_b = 0;
    tick_per = 4;
    RST = 1'b0;
    DATA_VALID_A = 0; P_DATA_A = '0; PAR_EN_A = 0; PAR_TYP_A = 0;
    DATA_VALID_B = 0; P_DATA_B = '0; PAR_EN_B = 0; PAR_TYP_B = 0;
    repeat (3) step();
    chk("rst_tx", TX_OUT_A, 1'b1);
    chk("rst_busy", BUSY_A, 1'b0);
    chk("rst_done", DONE_A, 1'b0);
    #2 RST = 1'b1;
    repeat (6) step();

    start = cap_a;
    send_a(8'hA5, 1'b0, 1'b0);
    wait_done("a5", 1'b0);
    chk_int("a5_len", cap_a - start, 10);
    check_bits("a5_bits", 1'b0, start, 10, 32'b1101001010);

    start = cap_a;
    send_a(8'h07, 1'b1, 1'b0);
    wait_done("p_even", 1'b0);
    chk_int("p_even_len", cap_a - start, 11);
    check_bits("p_even_bits", 1'b0, start, 11, 32'b11000001110);

    start = cap_a;
    send_a(8'h07, 1'b1, 1'b1);
    wait_done("p_odd", 1'b0);
    chk_int("p_odd_len", cap_a - start, 11);
    check_bits("p_odd_bits", 1'b0, start, 11, 32'b10000001110);

    // Back-to-back: request held high, second word accepted in the DONE cycle
    start = cap_a;
    DATA_VALID_A = 1'b1; P_DATA_A = 8'h55; PAR_EN_A = 1'b0; PAR_TYP_A = 1'b0;
    step(); step();
    P_DATA_A = 8'h33;
    wait_done("b2b1", 1'b0);
    DATA_VALID_A = 1'b0;
    wait_done("b2b2", 1'b0);
    chk_int("b2b_len", cap_a - start, 20);
    check_bits("b2b_first", 1'b0, start, 10, 32'b1010101010);
    check_bits("b2b_second", 1'b0, start + 10, 10, 32'b1001100110);

    // Request while busy must be ignored
    start = cap_a;
    send_a(8'h00, 1'b0, 1'b0);
    repeat (12) step();
    DATA_VALID_A = 1'b1; P_DATA_A = 8'hFF; PAR_EN_A = 1'b1; PAR_TYP_A = 1'b1;
    step();
    DATA_VALID_A = 1'b0;
    wait_done("ign", 1'b0);
    chk_int("ign_len", cap_a - start, 10);
    check_bits("ign_bits", 1'b0, start, 10, 32'b1000000000);

    // Reset during data bit 3
    start = cap_a;
    send_a(8'hA5, 1'b0, 1'b0);
    n = 0;
    while ((cap_a - start) < 5 && n < 200) begin step(); n++; end
    chk_int("rst_mid_reach", (cap_a - start) >= 5 ? 1 : 0, 1);
    step();
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_tx", TX_OUT_A, 1'b1);
    chk("rst_mid_busy", BUSY_A, 1'b0);
    chk("rst_mid_done", DONE_A, 1'b0);
    repeat (5) step();
    #2 RST = 1'b1;
    repeat (20) step();
    start = cap_a;
    send_a(8'h3C, 1'b1, 1'b1);
    wait_done("post_rst", 1'b0);
    chk_int("post_rst_len", cap_a - start, 11);
    check_bits("post_rst_bits", 1'b0, start, 11, 32'b11001111000);

    // 7 data bits, 2 stop bits, odd parity
    start = cap_b;
    DATA_VALID_B = 1'b1; P_DATA_B = 7'h41; PAR_EN_B = 1'b1; PAR_TYP_B = 1'b1;
    step();
    DATA_VALID_B = 1'b0;
    wait_done("w7", 1'b1);
    chk_int("w7_len", cap_b - start, 11);
    check_bits("w7_bits", 1'b1, start, 11, 32'b11110000010);

    // Randomized traffic on both instances against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) tick_per = $urandom_range(2, 6);
      DATA_VALID_A = ($urandom_range(0, 7) == 0);
      P_DATA_A     = 8'($urandom);
      PAR_EN_A     = 1'($urandom);
      PAR_TYP_A    = 1'($urandom);
      DATA_VALID_B = ($urandom_range(0, 5) == 0);
      P_DATA_B     = 7'($urandom);
      PAR_EN_B     = 1'($urandom);
      PAR_TYP_B    = 1'($urandom);
      step();
    end
    DATA_VALID_A = 1'b0;
    DATA_VALID_B = 1'b0;
    repeat (100) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
